// File: rtl/aes_decrypt_seq.sv
// Iterative AES-128 decryption sequencer: walks one ciphertext block through
// rounds NR..0 of a shared round datapath and returns the plaintext.
module aes_decrypt_seq #(
  parameter int unsigned NR     = 10,
  parameter int unsigned DP_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [127:0] dp_in,
  output logic [3:0]   dp_round,
  output logic [1:0]   dp_op,
  input  logic [127:0] dp_out,
  output logic         busy
);

  localparam int unsigned WaitW = (DP_LAT > 1) ? $clog2(DP_LAT + 1) : 1;

  localparam logic [1:0] OpFirst = 2'd0;
  localparam logic [1:0] OpRound = 2'd1;
  localparam logic [1:0] OpLast  = 2'd2;

  typedef enum logic [1:0] {StIdle, StRun, StWait, StDone} state_e;

  state_e             state_q, state_d;
  logic [127:0]       data_q, data_d;
  logic [127:0]       out_data_q, out_data_d;
  logic [127:0]       dp_in_q, dp_in_d;
  logic [3:0]         round_q, round_d;
  logic [3:0]         dp_round_q, dp_round_d;
  logic [1:0]         dp_op_q, dp_op_d;
  logic [1:0]         op_live;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               capture;

  always_comb begin
    if (round_q == 4'(NR)) begin
      op_live = OpFirst;
    end else if (round_q == 4'd0) begin
      op_live = OpLast;
    end else begin
      op_live = OpRound;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    round_d    = round_q;
    wait_d     = wait_q;
    out_data_d = out_data_q;
    dp_in_d    = dp_in_q;
    dp_round_d = dp_round_q;
    dp_op_d    = dp_op_q;
    capture    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          round_d = 4'(NR);
          state_d = StRun;
        end
      end
      StRun: begin
        // Snapshot what the datapath sees so it stays put through WAIT and after DONE.
        dp_in_d    = data_q;
        dp_round_d = round_q;
        dp_op_d    = op_live;
        if (DP_LAT == 0) begin
          capture = 1'b1;
        end else begin
          wait_d  = WaitW'(DP_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_q == WaitW'(1)) begin
          capture = 1'b1;
        end
        wait_d = wait_q - WaitW'(1);
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      if (round_q != 4'd0) begin
        data_d  = dp_out;
        round_d = round_q - 4'd1;
        state_d = StRun;
      end else begin
        out_data_d = dp_out;
        state_d    = StDone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      data_q     <= '0;
      round_q    <= '0;
      wait_q     <= '0;
      out_data_q <= '0;
      dp_in_q    <= '0;
      dp_round_q <= '0;
      dp_op_q    <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      round_q    <= round_d;
      wait_q     <= wait_d;
      out_data_q <= out_data_d;
      dp_in_q    <= dp_in_d;
      dp_round_q <= dp_round_d;
      dp_op_q    <= dp_op_d;
    end
  end

  // In RUN the datapath must see live values so a zero-latency result lands this cycle.
  assign dp_in     = (state_q == StRun) ? data_q  : dp_in_q;
  assign dp_round  = (state_q == StRun) ? round_q : dp_round_q;
  assign dp_op     = (state_q == StRun) ? op_live : dp_op_q;
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes_decrypt_seq.sv
// Bench for aes_decrypt_seq: two instances (DP_LAT 0 and 2) driven by an AES
// round-datapath model, checked against a textbook AES-128 inverse cipher.
module tb_aes_decrypt_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready, sel;
  logic [127:0] in_data;

  logic         in_ready0, out_valid0, busy0, in_ready2, out_valid2, busy2;
  logic [127:0] out_data0, dp_in0, dp_out0, out_data2, dp_in2, dp_out2;
  logic [3:0]   dp_round0, dp_round2;
  logic [1:0]   dp_op0, dp_op2;

  logic         in_ready_m, out_valid_m, busy_m;
  logic [127:0] out_data_m, dp_in_m;
  logic [3:0]   dp_round_m;
  logic [1:0]   dp_op_m;

  logic [7:0]   sbox [256];
  logic [7:0]   isbox[256];
  logic [127:0] rk   [11];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;

  aes_decrypt_seq #(.NR(10), .DP_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .dp_in(dp_in0),
    .dp_round(dp_round0), .dp_op(dp_op0), .dp_out(dp_out0), .busy(busy0)
  );

  aes_decrypt_seq #(.NR(10), .DP_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .dp_in(dp_in2),
    .dp_round(dp_round2), .dp_op(dp_op2), .dp_out(dp_out2), .busy(busy2)
  );

  assign in_ready_m  = sel ? in_ready2  : in_ready0;
  assign out_valid_m = sel ? out_valid2 : out_valid0;
  assign busy_m      = sel ? busy2      : busy0;
  assign out_data_m  = sel ? out_data2  : out_data0;
  assign dp_in_m     = sel ? dp_in2     : dp_in0;
  assign dp_round_m  = sel ? dp_round2  : dp_round0;
  assign dp_op_m     = sel ? dp_op2     : dp_op0;

  // ---------------- AES helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int k);
    return s[127-8*k -: 8];
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*((c+r)%4)) -: 8] = gb(s, r + 4*c);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = isbox[gb(s, k)];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
      o[127-8*(4*c)   -: 8] = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
      o[127-8*(4*c+1) -: 8] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
      o[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
      o[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
    end
    return o;
  endfunction

  // Shared round datapath as seen by the sequencer.
  function automatic logic [127:0] dp_fn(input logic [127:0] s, input logic [3:0] r,
                                         input logic [1:0] op);
    logic [127:0] t;
    t = s ^ rk[(r > 4'd10) ? 0 : int'(r)];
    case (op)
      2'd0:    return inv_sub_bytes(inv_shift_rows(t));
      2'd1:    return inv_sub_bytes(inv_shift_rows(inv_mix_columns(t)));
      default: return t;
    endcase
  endfunction

  // Textbook inverse cipher, independent of the datapath op grouping.
  function automatic logic [127:0] aes_dec(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[10];
    for (int r = 9; r >= 1; r--) begin
      s = inv_sub_bytes(inv_shift_rows(s)) ^ rk[r];
      s = inv_mix_columns(s);
    end
    return inv_sub_bytes(inv_shift_rows(s)) ^ rk[0];
  endfunction

  task automatic build_tables();
    logic [7:0] v, p, s;
    for (int x = 0; x < 256; x++) begin
      v = 8'(x);
      p = 8'h00;
      if (v != 8'h00) begin
        p = 8'h01;
        for (int k = 0; k < 254; k++) p = gmul(p, v);
      end
      for (int i = 0; i < 8; i++)
        s[i] = p[i] ^ p[(i+4)%8] ^ p[(i+5)%8] ^ p[(i+6)%8] ^ p[(i+7)%8];
      s = s ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = v;
    end
  endtask

  task automatic key_expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  assign dp_out0 = dp_fn(dp_in0, dp_round0, dp_op0);

  // Two-stage pipelined datapath for the DP_LAT=2 instance.
  logic [127:0] pipe_a, pipe_b;
  always @(posedge clk) begin
    pipe_a <= dp_fn(dp_in2, dp_round2, dp_op2);
    pipe_b <= pipe_a;
  end
  assign dp_out2 = pipe_b;

  // ---------------- bench tasks ----------------
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] ct);
    check("in_ready before send", 256'(in_ready_m), 256'(1));
    in_valid = 1'b1;
    in_data  = ct;
    tick();
    in_valid = 1'b0;
    in_data  = rand128();
  endtask

  // Follows one block from the accepting edge to out_valid, checking every cycle.
  task automatic run_ops(input logic [127:0] ct, input int lat);
    logic [127:0] inter[12];
    logic [1:0]   eop;
    logic [3:0]   er;
    int           k, j;
    inter[0] = ct;
    for (int i = 0; i <= 10; i++) begin
      eop = (i == 0) ? 2'd0 : ((i == 10) ? 2'd2 : 2'd1);
      inter[i+1] = dp_fn(inter[i], 4'(10 - i), eop);
    end
    k = 0;
    while (!out_valid_m && k < 300) begin
      j = k / (1 + lat);
      if (j <= 10) begin
        eop = (j == 0) ? 2'd0 : ((j == 10) ? 2'd2 : 2'd1);
        er  = 4'(10 - j);
        check("dp trace", {busy_m, in_ready_m, dp_op_m, dp_round_m, dp_in_m},
              {1'b1, 1'b0, eop, er, inter[j]});
      end else begin
        check("op overrun", 256'(k), 256'(11 * (1 + lat)));
      end
      tick();
      k++;
    end
    check("latency", 256'(k), 256'(11 * (1 + lat)));
    check("plaintext", 256'(out_data_m), 256'(aes_dec(ct)));
  endtask

  task automatic drain(input logic [127:0] ct, input int stall, input bit poke, input bit keep);
    logic [127:0] exp;
    exp = aes_dec(ct);
    for (int i = 0; i < stall; i++) begin
      check("done hold", {out_valid_m, in_ready_m, busy_m, out_data_m}, {3'b101, exp});
      if (poke) begin
        in_valid = 1'b1;
        in_data  = rand128();
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("idle after handshake", {out_valid_m, in_ready_m, busy_m}, 256'(3'b010));
    out_ready = keep;
  endtask

  task automatic random_blocks(input int n, input int lat);
    logic [127:0] ct;
    int           stall;
    for (int b = 0; b < n; b++) begin
      ct        = rand128();
      stall     = $urandom_range(0, 3);
      out_ready = (stall == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(ct);
      run_ops(ct, lat);
      drain(ct, stall, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int guard;
    build_tables();
    key_expand(C1Key);
    sel       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = C1Ct;
    out_ready = 1'b0;

    // Held in reset with in_valid high: nothing accepted, reset values visible.
    repeat (3) begin
      tick();
      check("reset ctrl", {in_ready_m, out_valid_m, busy_m, dp_round_m, dp_op_m},
            256'({3'b100, 4'd0, 2'd0}));
      check("reset out_data", 256'(out_data_m), 256'(0));
      check("reset dp_in", 256'(dp_in_m), 256'(0));
    end
    rst = 1'b0;
    tick();
    in_valid = 1'b0;
    check("accept after reset", 256'(busy_m), 256'(1));
    run_ops(C1Ct, 0);
    check("C.1 plaintext", 256'(out_data_m), 256'(C1Pt));
    drain(C1Ct, 20, 1'b1, 1'b0);

    // Back-to-back with out_ready held high.
    out_ready = 1'b1;
    send(C1Ct);
    run_ops(C1Ct, 0);
    drain(C1Ct, 0, 1'b0, 1'b1);
    send(128'h0);
    run_ops(128'h0, 0);
    drain(128'h0, 0, 1'b0, 1'b0);

    // Reset in the middle of a block.
    send(C1Ct);
    guard = 0;
    while (dp_round_m != 4'd5 && guard < 100) begin
      tick();
      guard++;
    end
    check("reach round 5", 256'(dp_round_m), 256'(5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid reset ctrl", {in_ready_m, out_valid_m, busy_m, dp_round_m, dp_op_m},
          256'({3'b100, 4'd0, 2'd0}));
    check("mid reset out_data", 256'(out_data_m), 256'(0));
    send(C1Ct);
    run_ops(C1Ct, 0);
    drain(C1Ct, 1, 1'b0, 1'b0);

    random_blocks(6, 0);

    // Switch to the DP_LAT=2 instance.
    sel = 1'b1;
    rst = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    send(C1Ct);
    run_ops(C1Ct, 2);
    check("C.1 plaintext lat2", 256'(out_data_m), 256'(C1Pt));
    drain(C1Ct, 3, 1'b1, 1'b1);
    send(128'h0);
    run_ops(128'h0, 2);
    drain(128'h0, 0, 1'b0, 1'b0);
    random_blocks(3, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_seq.md
Name: aes_decrypt_seq

Overview:
- Iterative AES-128 decryption sequencer.
- Accepts one 128-bit ciphertext block over a valid/ready handshake.
- Drives a single shared round datapath (round decrypt unit plus addRoundKey-only path) through rounds 10 down to 0, with the round key selected by round index inside the datapath.
- Returns the 128-bit plaintext over a valid/ready handshake. Sits between the fingerprint-template storage interface and the shared decrypt datapath.

Parameters:
- NR, 10, number of AES rounds; fixed at 10 for AES-128, other values unsupported.
- DP_LAT, 0, datapath latency in cycles; 0 means dp_out is combinational from dp_in/dp_round/dp_op.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  ciphertext available
- in_ready  out  1  sequencer can accept ciphertext
- in_data  in  128  ciphertext block
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts plaintext
- out_data  out  128  plaintext block
- dp_in  out  128  state presented to datapath
- dp_round  out  4  round index (key select) presented to datapath
- dp_op  out  2  0=FIRST (ARK, invShiftRows, invSubBytes); 1=ROUND (ARK, invMixColumns, invShiftRows, invSubBytes); 2=LAST (ARK only); 3 never driven
- dp_out  in  128  datapath result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, dp_in=0, dp_round=0, dp_op=0, busy=0, wait counter=0.
- Reset mid-operation: state discarded, no output produced, IDLE on the next cycle.
- States: IDLE, RUN, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state reg <= in_data, round <= NR, go to RUN.
- RUN:
  - dp_in=state reg, dp_round=round.
  - dp_op=FIRST when round==NR, LAST when round==0, else ROUND.
  - If DP_LAT==0: state reg <= dp_out at the end of this cycle.
  - If DP_LAT>0: go to WAIT with wait counter=DP_LAT; dp_in, dp_round and dp_op held stable throughout WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At count 1: capture dp_out, counter -> 0.
- Advance after each capture:
  - round>0: round <= round-1, stay in or return to RUN.
  - round==0: out_data <= captured value, out_valid <= 1, go to DONE.
- Op sequence per block: FIRST(10), ROUND(9..1), LAST(0). That is exactly 11 datapath ops. No round index is ever skipped or repeated.
- Latency with DP_LAT=0: out_valid rises 11 cycles after the accepting edge. In general: 11*(1+DP_LAT) cycles.
- DONE:
  - out_valid=1; out_data stable until the handshake.
  - On out_ready: out_valid <= 0, go to IDLE.
  - Back-to-back: a new block can be accepted the cycle after the output handshake. No overlap of in/out handshakes, since in_ready=0 outside IDLE.
- in_ready=0 in RUN, WAIT and DONE. in_valid is ignored there and in_data is not sampled.
- dp_* outputs in IDLE/DONE: hold last values; the datapath must not rely on them.
- Round counter is 4 bits. It decrements from NR to 0 and never wraps below 0.
- out_ready asserted while not in DONE: ignored.

Test Plan:
- FIPS-197 C.1 vector, datapath key 000102030405060708090a0b0c0d0e0f, DP_LAT=0, in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff; out_valid 11 cycles after accept; dp_round trace 10,9,...,0; dp_op trace FIRST, 9×ROUND, LAST.
- Same vector with DP_LAT=2 -> same plaintext, out_valid after 33 cycles, dp_* stable during every WAIT cycle.
- out_ready held low 20 cycles in DONE -> out_valid and out_data held constant, in_ready=0, a second in_valid ignored. After out_ready=1, IDLE and next block accepted the following cycle.
- Two back-to-back blocks (C.1 ciphertext, then the all-zero ciphertext with known model result) with out_ready=1 -> both plaintexts correct and in order, no duplicated or dropped ops.
- rst pulsed at round 5 of a block -> next cycle IDLE, in_ready=1, out_valid=0, busy=0. A subsequent block decrypts correctly.
- in_valid asserted during reset -> not accepted. First acceptance occurs on the first cycle after rst deasserts.
